// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared definitions for the serial frame transmitter.
//   state_t           frame FSM encodings (2 bits)
//   LINE_IDLE/...     line levels driven on tx
//   DEF_*             default frame geometry
package serial_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick: bit-period timer for serial_tx.
//   clk    in  clock
//   rst_n  in  async active-low reset
//   clear  in  hold the count at zero (no tick while asserted)
//   tick   out high in the last clock of each CLKS_PER_BIT period
// Counts 0..CLKS_PER_BIT-1 and wraps; the tick coincides with the wrap.
module baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_LAST) && !clear;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
//   clk    in  clock
//   rst_n  in  async active-low reset
//   data   in  word to send, sampled on the accept edge
//   valid  in  word offered
//   ready  out idle, able to accept
//   tx     out serial line (registered, idle high)
//   busy   out frame in progress
//   done   out one-clock pulse after the stop bit
// Frame: start(0), DATA_W bits LSB first, stop(1), each CLKS_PER_BIT clocks.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | line high, ready; accept on valid
//   S_START | start bit on tx
//   S_DATA  | data bits on tx, LSB first
//   S_STOP  | stop bit on tx; done pulses on its last tick
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int BIT_W = $clog2(DATA_W) + 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   state_t            state_q,   state_d;
   logic [DATA_W-1:0] shift_q,   shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              tx_q,      tx_d;
   logic              done_q,    done_d;
   logic              tick;

   // Holding the timer clear while idle means the accept edge always
   // starts the first bit period from zero.
   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(state_q == S_IDLE),
      .tick (tick)
   );

   assign ready = (state_q == S_IDLE);
   assign busy  = !ready;
   assign tx    = tx_q;
   assign done  = done_q;

   // tx_d is the level for the next cycle, so it follows state_d.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = LINE_IDLE;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               state_d   = S_START;
               shift_d   = data;
               bit_cnt_d = '0;
               tx_d      = START_BIT;
            end
         end
         S_START: begin
            tx_d = START_BIT;
            if (tick) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               tx_d      = shift_d[0];
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = S_STOP;
                  tx_d    = STOP_BIT;
               end
            end
         end
         S_STOP: begin
            tx_d = STOP_BIT;
            if (tick) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= LINE_IDLE;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          valid;
   logic          ready, tx, busy, done;

   logic          data1;
   logic          valid1;
   logic          ready1, tx1, busy1, done1;

   int cyc    = 0;
   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .data (data),
      .valid(valid),
      .ready(ready),
      .tx   (tx),
      .busy (busy),
      .done (done)
   );

   serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut1 (
      .clk  (clk),
      .rst_n(rst_n),
      .data (data1),
      .valid(valid1),
      .ready(ready1),
      .tx   (tx1),
      .busy (busy1),
      .done (done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Starts at the negedge before the accepting edge; ends at the negedge of
   // the done cycle. Line levels come from a list of frame bits.
   task automatic expect_frame(input logic [DW-1:0] d, input int poke_at,
                               input logic nv, input logic [DW-1:0] nd,
                               output int done_cyc);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      bits.push_back(1'b1);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         chk("frame_tx",    tx,    bits[k / CPB]);
         chk("frame_busy",  busy,  1);
         chk("frame_ready", ready, 0);
         chk("frame_done",  done,  0);
         if (k == 0) begin
            valid = nv;
            data  = nd;
         end
         if (k == poke_at) begin
            data  = 8'h3C;
            valid = 1'b1;
         end
         if (k == poke_at + 1) begin
            valid = nv;
            data  = nd;
         end
      end
      @(negedge clk);
      chk("end_done",  done,  1);
      chk("end_ready", ready, 1);
      chk("end_busy",  busy,  0);
      chk("end_tx",    tx,    1);
      done_cyc = cyc;
   endtask

   task automatic expect_frame1(input logic d);
      logic bits[$];
      bits = '{1'b0, d, 1'b1};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("f1_tx",   tx1,   bits[k]);
         chk("f1_done", done1, 0);
         chk("f1_busy", busy1, 1);
         if (k == 0) valid1 = 1'b0;
      end
      @(negedge clk);
      chk("f1_end_done",  done1,  1);
      chk("f1_end_tx",    tx1,    1);
      chk("f1_end_ready", ready1, 1);
   endtask

   initial begin
      int d0, d1, d2;
      logic [DW-1:0] rnd [6];
      logic [DW-1:0] rd;

      rst_n  = 1'b0;
      valid  = 1'b1;
      data   = 8'hA5;
      valid1 = 1'b1;
      data1  = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_tx",    tx,    1);
         chk("rst_ready", ready, 1);
         chk("rst_busy",  busy,  0);
         chk("rst_done",  done,  0);
         chk("rst_tx1",   tx1,   1);
      end
      rst_n  = 1'b1;
      valid1 = 1'b0;

      expect_frame(8'hA5, -1, 1'b0, 8'h00, d0);

      @(negedge clk);
      chk("idle_done",  done,  0);
      chk("idle_ready", ready, 1);
      chk("idle_tx",    tx,    1);
      data  = 8'hA5;
      valid = 1'b1;
      expect_frame(8'hA5, 13, 1'b0, 8'hA5, d0);

      @(negedge clk);
      data  = 8'h00;
      valid = 1'b1;
      expect_frame(8'h00, -1, 1'b1, 8'hFF, d1);
      expect_frame(8'hFF, -1, 1'b0, 8'h00, d2);
      chk("b2b_spacing", d2 - d1, FRAME + 1);

      for (int i = 0; i < 6; i++) rnd[i] = DW'($urandom);
      @(negedge clk);
      data  = rnd[0];
      valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         expect_frame(rnd[i], -1, (i < 5), (i < 5) ? rnd[(i + 1) % 6] : 8'h00, d0);
      end

      @(negedge clk);
      rd    = DW'($urandom);
      data  = rd;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_bit3", tx, rd[3]);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx",    tx,    1);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_busy",  busy,  0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_done", done, 0);
         chk("mid_rst_hold", tx,   1);
      end
      rst_n = 1'b1;
      data  = 8'h81;
      valid = 1'b1;
      expect_frame(8'h81, -1, 1'b0, 8'h00, d0);

      @(negedge clk);
      data1  = 1'b1;
      valid1 = 1'b1;
      expect_frame1(1'b1);
      @(negedge clk);
      data1  = 1'b0;
      valid1 = 1'b1;
      expect_frame1(1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
